// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with a small TX FIFO
// TXDATA stores queue bytes; STATUS loads report FIFO and shifter state combinationally.
module mmio_uart_tx #(
  parameter int           W          = 32,
  parameter logic [W-1:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int           CLK_DIV    = 16,
  parameter int           FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  output logic         l_hit,
  output logic         tx,
  output logic         busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [W-1:0]  A_TXDATA = BASE_ADDR;
  localparam logic [W-1:0]  A_STATUS = BASE_ADDR + W'(4);
  localparam logic [W-1:0]  A_CTRL   = BASE_ADDR + W'(8);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_TC  = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_idx;
  logic [BW-1:0] r_baud;
  logic          r_tx;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_txdata;
  logic          w_wr_ctrl;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_tc;
  logic [W-1:0]  w_status;
  logic          w_unused_sdata;

  assign w_full         = (r_count == DEPTH_C);
  assign w_empty        = (r_count == '0);
  assign w_wr_txdata    = store_en && (s_addr == A_TXDATA);
  assign w_wr_ctrl      = store_en && (s_addr == A_CTRL);
  assign w_push         = w_wr_txdata && !w_full;
  assign w_pop          = (r_state == S_IDLE) && !w_empty;
  assign w_baud_tc      = (r_baud == BAUD_TC);
  assign w_unused_sdata = &{1'b0, s_data[W-1:8]};

  assign tx   = r_tx;
  assign busy = (r_state != S_IDLE) || !w_empty;

  always_comb begin
    w_status          = '0;
    w_status[0]       = w_full;
    w_status[1]       = w_empty;
    w_status[2]       = busy;
    w_status[3]       = r_overflow;
    w_status[8 +: CW] = r_count;
  end

  always_comb begin
    l_hit  = load_en && ((l_addr == A_TXDATA) || (l_addr == A_STATUS) || (l_addr == A_CTRL));
    l_data = (load_en && (l_addr == A_STATUS)) ? w_status : '0;
  end

  // Full is sampled before the edge, so a pop on the same edge cannot make room for a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_wr_txdata && w_full) r_overflow <= 1'b1;
      else if (w_wr_ctrl)        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_baud    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (!w_empty) begin
            r_shift <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_tc) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_tc) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_tc) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed bench with a serial-frame scoreboard for mmio_uart_tx
// A monitor decodes every frame on tx cycle-by-cycle and compares it with the queued bytes.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk;
  logic        rst;
  logic        store_en;
  logic [31:0] s_addr;
  logic [31:0] s_data;
  logic        load_en;
  logic [31:0] l_addr;
  logic [31:0] l_data;
  logic        l_hit;
  logic        tx;
  logic        busy;

  int checks      = 0;
  int errors      = 0;
  int frames_done = 0;
  int aborts      = 0;
  logic [7:0] exp_q[$];
  int         gaps[$];

  mmio_uart_tx #(
    .W(32), .BASE_ADDR(BASE), .CLK_DIV(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .store_en(store_en), .s_addr(s_addr), .s_data(s_data),
    .load_en(load_en), .l_addr(l_addr), .l_data(l_data), .l_hit(l_hit),
    .tx(tx), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit accept);
    store_en = 1'b1;
    s_addr   = a;
    s_data   = d;
    if (accept) exp_q.push_back(d[7:0]);
    @(posedge clk);
    #1;
    store_en = 1'b0;
    s_addr   = '0;
    s_data   = '0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic exp_hit,
                            input logic [31:0] exp_data);
    load_en = 1'b1;
    l_addr  = a;
    #1;
    check({tag, "_hit"}, {31'b0, l_hit}, {31'b0, exp_hit});
    check({tag, "_data"}, l_data, exp_data);
    load_en = 1'b0;
    l_addr  = '0;
  endtask

  task automatic wait_frames(input string tag, input int target);
    for (int i = 0; i < 3000 && frames_done < target; i++) @(negedge clk);
    check(tag, frames_done, target);
  endtask

  // Frame monitor: 10 bits x 4 cycles each, sampled on every negedge.
  initial begin : monitor
    logic [39:0] got;
    logic [39:0] exp;
    logic [7:0]  e;
    logic        bv;
    bit          aborted;
    int          hi;
    hi = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hi = 0;
      end else if (tx === 1'b1) begin
        hi++;
      end else begin
        got     = '0;
        got[0]  = tx;
        aborted = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          got[i] = tx;
        end
        if (aborted) begin
          aborts++;
          hi = 0;
        end else begin
          gaps.push_back(hi);
          hi = 0;
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL frame_unexpected: got frame %h expected none", got);
          end
          if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            exp = '0;
            for (int b = 0; b < 10; b++) begin
              bv = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : e[b-1]);
              for (int k = 0; k < 4; k++) exp[b*4+k] = bv;
            end
            checks++;
            assert (got === exp) else begin
              errors++;
              $error("FAIL frame_%02h: got %h expected %h", e, got, exp);
            end
          end
          frames_done++;
        end
      end
    end
  end

  initial begin : stim
    int  base_f;
    bit  seen_low;
    rst      = 1'b1;
    store_en = 1'b0;
    s_addr   = '0;
    s_data   = '0;
    load_en  = 1'b0;
    l_addr   = '0;

    // Reset state and address decode
    #2;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("idle_tx", {31'b0, tx}, 32'd1);
    load_check("status", BASE + 32'd4, 1'b1, 32'h0000_0002);
    load_check("beyond", BASE + 32'd12, 1'b0, 32'h0);
    load_check("txdata_rd", BASE, 1'b1, 32'h0);
    load_check("ctrl_rd", BASE + 32'd8, 1'b1, 32'h0);
    load_check("misaligned", BASE + 32'd5, 1'b0, 32'h0);
    l_addr = BASE + 32'd4;
    #1;
    check("no_load_hit", {31'b0, l_hit}, 32'd0);
    check("no_load_data", l_data, 32'h0);
    l_addr = '0;
    store(BASE + 32'd4, 32'h55, 1'b0);
    load_check("status_wr_ignored", BASE + 32'd4, 1'b1, 32'h0000_0002);

    // Single byte 0xA5, exact latency and busy release
    store(BASE, 32'h1234_56A5, 1'b1);
    load_check("status_one", BASE + 32'd4, 1'b1, 32'h0000_0104);
    @(negedge clk);
    check("lat_still_high", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check("lat_fell", {31'b0, tx}, 32'd0);
    wait_frames("frame_a5_done", 1);
    check("busy_in_stop", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("busy_dropped", {31'b0, busy}, 32'd0);
    load_check("status_after_a5", BASE + 32'd4, 1'b1, 32'h0000_0002);

    // Six back-to-back stores into a 4-deep FIFO
    gaps.delete();
    base_f = frames_done;
    store(BASE, 32'h01, 1'b1);
    check("b2b_tx_before_pop", {31'b0, tx}, 32'd1);
    store(BASE, 32'h02, 1'b1);
    check("b2b_tx_popped", {31'b0, tx}, 32'd0);
    store(BASE, 32'h03, 1'b1);
    store(BASE, 32'h04, 1'b1);
    store(BASE, 32'h05, 1'b1);
    store(BASE, 32'h06, 1'b0);
    load_check("status_full_ovf", BASE + 32'd4, 1'b1, 32'h0000_040D);
    wait_frames("b2b_done", base_f + 5);
    check("b2b_gap_count", gaps.size(), 32'd5);
    for (int i = 1; i < gaps.size() && i < 5; i++) check("b2b_gap", gaps[i], 32'd1);
    repeat (3) @(negedge clk);
    load_check("status_ovf_sticky", BASE + 32'd4, 1'b1, 32'h0000_000A);
    store(BASE + 32'd8, 32'h0, 1'b0);
    load_check("status_ovf_clr", BASE + 32'd4, 1'b1, 32'h0000_0002);

    // Overflow clear with full FIFO, then push+pop on the same edge while full
    gaps.delete();
    base_f = frames_done;
    store(BASE, 32'hA1, 1'b1);
    store(BASE, 32'hB1, 1'b1);
    store(BASE, 32'hB2, 1'b1);
    store(BASE, 32'hB3, 1'b1);
    store(BASE, 32'hB4, 1'b1);
    store(BASE, 32'hB5, 1'b0);
    load_check("status_full2", BASE + 32'd4, 1'b1, 32'h0000_040D);
    store(BASE + 32'd8, 32'hDEAD_BEEF, 1'b0);
    load_check("status_clr_full", BASE + 32'd4, 1'b1, 32'h0000_0405);
    repeat (35) @(posedge clk);
    #1;
    load_check("status_before_pop", BASE + 32'd4, 1'b1, 32'h0000_0405);
    store(BASE, 32'hB6, 1'b0);
    load_check("status_push_pop_full", BASE + 32'd4, 1'b1, 32'h0000_030C);
    wait_frames("fill_done", base_f + 5);
    for (int i = 1; i < gaps.size() && i < 5; i++) check("fill_gap", gaps[i], 32'd1);
    repeat (3) @(negedge clk);
    load_check("status_drained", BASE + 32'd4, 1'b1, 32'h0000_000A);

    // Reset during DATA bit 3 of 0xF0
    store(BASE, 32'hF0, 1'b1);
    repeat (18) @(posedge clk);
    #1;
    check("bit3_low", {31'b0, tx}, 32'd0);
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("rst_tx_async", {31'b0, tx}, 32'd1);
    check("rst_busy_async", {31'b0, busy}, 32'd0);
    load_check("status_in_rst", BASE + 32'd4, 1'b1, 32'h0000_0002);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    load_check("status_after_rst", BASE + 32'd4, 1'b1, 32'h0000_0002);
    base_f   = frames_done;
    seen_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    check("no_residual_tx", {31'b0, seen_low}, 32'd0);
    check("no_residual_frame", frames_done, base_f);
    check("frame_aborted", aborts, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
